// File: rtl/new_arbitro.sv
// new_arbitro: sends a 32-bit word MSB-byte-first as four UART frames whenever a send is pending or the word changes while idle.
// Define NEW_ARBITRO_PARITY_EN for 8E1 frames (even parity bit after data bit 7); default build is 8N1.
module new_arbitro #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] in,
    output logic        tx,
    output logic        tx_Done
);

    localparam int CW = $clog2(CLKS_PER_BIT);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        DATA,
`ifdef NEW_ARBITRO_PARITY_EN
        PARITY,
`endif
        STOP,
        DONE
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] clk_cnt, clk_cnt_n;
    logic [2:0]    bit_idx, bit_n;
    logic [1:0]    byte_idx, byte_n;
    logic [31:0]   shadow, shadow_n;
    logic [31:0]   last_sent, last_n;
    logic          pending, pending_n;
    logic          tx_r, tx_n;
    logic          bit_end;
    logic [31:0]   sh_word;
    logic [7:0]    byte_sel;

    assign bit_end = (clk_cnt == CW'(CLKS_PER_BIT - 1));
    assign tx      = tx_r;
    assign tx_Done = (state == DONE);

    always_comb begin
        state_n   = state;
        clk_cnt_n = clk_cnt;
        bit_n     = bit_idx;
        byte_n    = byte_idx;
        shadow_n  = shadow;
        last_n    = last_sent;
        pending_n = pending;
        tx_n      = 1'b1;
        sh_word   = 32'd0;
        byte_sel  = 8'd0;

        case (state)
            IDLE: begin
                // An X/Z word makes this condition unknown, which does not trigger a send.
                if (pending || (in != last_sent)) state_n = LOAD;
            end
            LOAD: begin
                shadow_n  = in;
                last_n    = in;
                pending_n = 1'b0;
                byte_n    = 2'd0;
                bit_n     = 3'd0;
                clk_cnt_n = '0;
                state_n   = START;
            end
            START: begin
                if (bit_end) begin
                    clk_cnt_n = '0;
                    state_n   = DATA;
                end else begin
                    clk_cnt_n = clk_cnt + CW'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    clk_cnt_n = '0;
                    bit_n     = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
`ifdef NEW_ARBITRO_PARITY_EN
                        state_n = PARITY;
`else
                        state_n = STOP;
`endif
                    end
                end else begin
                    clk_cnt_n = clk_cnt + CW'(1);
                end
            end
`ifdef NEW_ARBITRO_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    clk_cnt_n = '0;
                    state_n   = STOP;
                end else begin
                    clk_cnt_n = clk_cnt + CW'(1);
                end
            end
`endif
            STOP: begin
                // The next-byte decision happens here so frames follow back to back.
                if (bit_end) begin
                    clk_cnt_n = '0;
                    if (byte_idx != 2'd3) begin
                        byte_n  = byte_idx + 2'd1;
                        state_n = START;
                    end else begin
                        state_n = DONE;
                    end
                end else begin
                    clk_cnt_n = clk_cnt + CW'(1);
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase

        // tx is registered from the upcoming state, so the line moves on the same edge as the state.
        sh_word  = shadow_n >> {~byte_n, 3'b000};
        byte_sel = sh_word[7:0];
        case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = byte_sel[bit_n];
`ifdef NEW_ARBITRO_PARITY_EN
            PARITY:  tx_n = ^byte_sel;
`endif
            default: tx_n = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            clk_cnt   <= '0;
            bit_idx   <= 3'd0;
            byte_idx  <= 2'd0;
            shadow    <= 32'd0;
            last_sent <= 32'd0;
            pending   <= 1'b1;
            tx_r      <= 1'b1;
        end else begin
            state     <= state_n;
            clk_cnt   <= clk_cnt_n;
            bit_idx   <= bit_n;
            byte_idx  <= byte_n;
            shadow    <= shadow_n;
            last_sent <= last_n;
            pending   <= pending_n;
            tx_r      <= tx_n;
        end
    end

endmodule

// File: tb/tb_new_arbitro.sv
// Bench for new_arbitro: a UART receiver decodes tx at mid-bit and checks bytes, framing and tx_Done timing.
module tb_new_arbitro;
    localparam int CPB = 4;
`ifdef NEW_ARBITRO_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int WORD_CYC = 4 * NB * CPB;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] in = 32'd0;
    logic        tx;
    logic        tx_Done;

    new_arbitro #(.CLKS_PER_BIT(CPB)) dut (
        .clk     (clk),
        .reset   (reset),
        .in      (in),
        .tx      (tx),
        .tx_Done (tx_Done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_word(input logic [31:0] w);
        exp_q.push_back(w[31:24]);
        exp_q.push_back(w[23:16]);
        exp_q.push_back(w[15:8]);
        exp_q.push_back(w[7:0]);
    endtask

    // Receiver and tx_Done monitor, sampling on the falling edge.
    logic       rx_busy = 1'b0;
    int         rx_t = 0;
    int         rx_bit = 0;
    logic [7:0] rx_byte = 8'd0;
    int         frame_idx = 0;
    int         prev_start = 0;
    int         word_start = 0;
    logic       word_complete = 1'b0;
    int         done_cnt = 0;
    logic       done_prev = 1'b0;
    int         set_cyc = 0;

    always @(negedge clk) begin
        if (tx_Done === 1'b1) begin
            done_cnt++;
            check("done_width", done_prev, 0);
            check("done_after_word", word_complete, 1);
            check("done_latency", cyc - word_start, WORD_CYC);
            word_complete = 1'b0;
        end
        done_prev = (tx_Done === 1'b1);

        if (reset !== 1'b1) begin
            rx_busy       = 1'b0;
            frame_idx     = 0;
            word_complete = 1'b0;
        end else begin
            if (!rx_busy) begin
                if (tx === 1'b0) begin
                    rx_busy = 1'b1;
                    rx_t    = 0;
                    if (frame_idx == 0) word_start = cyc;
                    else check("frame_gap", cyc - prev_start, NB * CPB);
                    prev_start = cyc;
                end
            end else begin
                rx_t++;
            end
            if (rx_busy && (rx_t % CPB) == (CPB / 2 - 1)) begin
                rx_bit = rx_t / CPB;
                if (rx_bit == 0) begin
                    check("start_bit", tx, 0);
                end else if (rx_bit <= 8) begin
                    rx_byte[rx_bit-1] = tx;
`ifdef NEW_ARBITRO_PARITY_EN
                end else if (rx_bit == 9) begin
                    check("parity_bit", tx, ^rx_byte);
`endif
                end else begin
                    check("stop_bit", tx, 1);
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_byte: got %h expected none", rx_byte);
                    end else begin
                        check("byte", rx_byte, exp_q.pop_front());
                    end
                    rx_busy   = 1'b0;
                    frame_idx = (frame_idx + 1) % 4;
                    if (frame_idx == 0) word_complete = 1'b1;
                end
            end
        end
    end

    task automatic wait_done(input int budget);
        int d0;
        int t;
        d0 = done_cnt;
        t  = 0;
        while (done_cnt == d0 && t < budget) begin
            @(posedge clk);
            t++;
        end
        check("done_timeout", (done_cnt != d0), 1);
        #1;
    endtask

    task automatic do_reset(input logic [31:0] w);
        @(posedge clk); #1;
        reset = 1'b0;
        in    = w;
        repeat (2) @(posedge clk);
        #1;
        check("reset_tx", tx, 1);
        check("reset_done", tx_Done, 0);
        exp_q.delete();
        reset   = 1'b1;
        set_cyc = cyc;
    endtask

    task automatic wait_frame(input int idx);
        int t;
        t = 0;
        while (!(rx_busy && frame_idx == idx) && t < 1000) begin
            @(posedge clk);
            t++;
        end
        check("frame_wait_timeout", (t < 1000), 1);
        #1;
    endtask

    typedef struct {
        logic        rst;
        logic [31:0] word;
        logic [7:0]  b0, b1, b2, b3;
    } vec_t;

    vec_t        vecs[6];
    int          d_before;
    int          bad_tx;
    logic [31:0] model_last;
    logic [31:0] w1, w2;
    logic        two;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b1, 32'h0000_0001, 8'h00, 8'h00, 8'h00, 8'h01};
        vecs[1] = '{1'b1, 32'h0000_0002, 8'h00, 8'h00, 8'h00, 8'h02};
        vecs[2] = '{1'b0, 32'hDEAD_BEEF, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        vecs[3] = '{1'b0, 32'h1234_5678, 8'h12, 8'h34, 8'h56, 8'h78};
        vecs[4] = '{1'b0, 32'h80FF_0055, 8'h80, 8'hFF, 8'h00, 8'h55};
        vecs[5] = '{1'b1, 32'h80FF_0055, 8'h80, 8'hFF, 8'h00, 8'h55};

        for (int i = 0; i < 6; i++) begin
            if (vecs[i].rst) begin
                do_reset(vecs[i].word);
            end else begin
                @(posedge clk); #1;
                in      = vecs[i].word;
                set_cyc = cyc;
            end
            exp_q.push_back(vecs[i].b0);
            exp_q.push_back(vecs[i].b1);
            exp_q.push_back(vecs[i].b2);
            exp_q.push_back(vecs[i].b3);
            d_before = done_cnt;
            wait_done(WORD_CYC + 50);
            check("start_latency", word_start - set_cyc, 2);
            repeat (5) @(posedge clk);
            #1;
            check("done_count", done_cnt - d_before, 1);
            check("idle_tx", tx, 1);
        end

        // Word changes during byte 1: current word finishes, then the new one follows.
        @(posedge clk); #1;
        in = 32'hA0A1_A2A3;
        push_word(32'hA0A1_A2A3);
        wait_frame(1);
        in = 32'h1234_5678;
        push_word(32'h1234_5678);
        wait_done(WORD_CYC + 50);
        wait_done(WORD_CYC + 50);
        check("queue_after_change", exp_q.size(), 0);

        // Reset during byte 2 aborts without tx_Done, then resends from byte 0.
        @(posedge clk); #1;
        in = 32'hCAFE_F00D;
        push_word(32'hCAFE_F00D);
        wait_frame(2);
        d_before = done_cnt;
        reset = 1'b0;
        @(posedge clk); #1;
        check("abort_tx", tx, 1);
        bad_tx = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (tx !== 1'b1) bad_tx++;
        end
        check("abort_idle_tx", bad_tx, 0);
        check("abort_no_done", done_cnt - d_before, 0);
        exp_q.delete();
        reset   = 1'b1;
        set_cyc = cyc;
        push_word(32'hCAFE_F00D);
        wait_done(WORD_CYC + 50);
        check("resend_latency", word_start - set_cyc, 2);

        // Unknown word while idle does not start a send.
        do_reset(32'd0);
        push_word(32'd0);
        wait_done(WORD_CYC + 50);
        d_before = done_cnt;
        in = 32'hxxxx_xxxx;
        bad_tx = 0;
        repeat (60) begin
            @(posedge clk); #1;
            if (tx !== 1'b1) bad_tx++;
        end
        check("x_idle_tx", bad_tx, 0);
        check("x_no_done", done_cnt - d_before, 0);
        in = 32'd0;
        model_last = 32'd0;
        repeat (10) @(posedge clk);
        #1;

        // Randomized words, some changed mid-flight; the model sends whatever differs from the last word sent.
        for (int k = 0; k < 10; k++) begin
            w1 = $urandom;
            if (w1 == model_last) w1 = ~w1;
            in         = w1;
            set_cyc    = cyc;
            push_word(w1);
            model_last = w1;
            two        = 1'b0;
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(10, 120)) @(posedge clk);
                #1;
                w2 = ($urandom_range(0, 3) == 0) ? w1 : $urandom;
                in = w2;
                if (w2 != model_last) begin
                    push_word(w2);
                    model_last = w2;
                    two        = 1'b1;
                end
            end
            wait_done(WORD_CYC + 200);
            check("rand_latency", word_start - set_cyc, 2);
            if (two) wait_done(WORD_CYC + 50);
            repeat ($urandom_range(1, 8)) @(posedge clk);
            #1;
        end

        repeat (30) @(posedge clk);
        #1;
        check("queue_drained", exp_q.size(), 0);
        check("final_tx", tx, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
